// File: rtl/operand_fetch_if.sv
// Bundle of the instruction, register-file and ALU-side signals around operand_fetch.
// The master modport is the operand stage itself; slave is its surrounding environment.
interface operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 6
);
  localparam int INSTR_W = OPC_W + 2 * ADDR_W;

  // Instruction stream from decode
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  // Register file read port (registered read data)
  logic               reg_read_en;
  logic [ADDR_W-1:0]  reg_read_addr_1;
  logic [ADDR_W-1:0]  reg_read_addr_2;
  logic [DATA_W-1:0]  reg_read_data_1;
  logic [DATA_W-1:0]  reg_read_data_2;

  // Monitor copy of the register file write port
  logic               wb_write_en;
  logic [ADDR_W-1:0]  wb_write_dest;
  logic [DATA_W-1:0]  wb_write_data;

  // Operands to the ALU
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [ADDR_W-1:0]  out_rd;
  logic [DATA_W-1:0]  out_op_a;
  logic [DATA_W-1:0]  out_op_b;

  modport master (
    input  in_valid, in_instr,
    output in_ready,
    output reg_read_en, reg_read_addr_1, reg_read_addr_2,
    input  reg_read_data_1, reg_read_data_2,
    input  wb_write_en, wb_write_dest, wb_write_data,
    output out_valid, out_opcode, out_rd, out_op_a, out_op_b,
    input  out_ready
  );

  modport slave (
    output in_valid, in_instr,
    input  in_ready,
    input  reg_read_en, reg_read_addr_1, reg_read_addr_2,
    output reg_read_data_1, reg_read_data_2,
    output wb_write_en, wb_write_dest, wb_write_data,
    input  out_valid, out_opcode, out_rd, out_op_a, out_op_b,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: reads both source registers and hands them to the ALU.
// Define OPFETCH_FWD_EN to forward write-back data on a DATA-cycle collision instead of re-reading.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  operand_fetch_if.master  bus,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [1:0]       state_dbg
);
  localparam int INSTR_W = OPC_W + 2 * ADDR_W;

`ifdef OPFETCH_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DATA  = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  op_a_q;
  logic [DATA_W-1:0]  op_b_q;
  logic [CNT_W-1:0]   blk_cnt_q;
  logic [ADDR_W-1:0]  rs1;
  logic [ADDR_W-1:0]  rs2;
  logic               coll_a;
  logic               coll_b;
  logic               in_ready_c;
  logic               accept;
  logic               capture;
  logic               blocked;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; a sender holds valid and payload stable until that edge, and out_* here
  // never change while out_valid is high and out_ready is low.

  assign rs1 = instr_q[2*ADDR_W-1:ADDR_W];
  assign rs2 = instr_q[ADDR_W-1:0];

  // A write-back to a source register while its read data is on the bus makes that data stale.
  assign coll_a = bus.wb_write_en && (bus.wb_write_dest == rs1);
  assign coll_b = bus.wb_write_en && (bus.wb_write_dest == rs2);

  always_comb begin
    state_n    = state;
    in_ready_c = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_n = ST_READ;
      end
      ST_READ: begin
        // The register file gives the write port priority, so a write cancels this read.
        if (!bus.wb_write_en) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (!FWD_EN && (coll_a || coll_b)) begin
          state_n = ST_READ;
        end else begin
          capture = 1'b1;
          state_n = ST_VALID;
        end
      end
      ST_VALID: begin
        if (bus.out_ready) begin
          in_ready_c = 1'b1;
          state_n    = bus.in_valid ? ST_READ : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign accept  = bus.in_valid && in_ready_c;
  assign blocked = (state == ST_READ) && bus.wb_write_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (accept) instr_q <= bus.in_instr;
      if (capture) begin
        op_a_q <= (FWD_EN && coll_a) ? bus.wb_write_data : bus.reg_read_data_1;
        op_b_q <= (FWD_EN && coll_b) ? bus.wb_write_data : bus.reg_read_data_2;
      end
      if (blocked && (blk_cnt_q != {CNT_W{1'b1}})) blk_cnt_q <= blk_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready        = in_ready_c;
  assign bus.reg_read_en     = (state == ST_READ);
  assign bus.reg_read_addr_1 = rs1;
  assign bus.reg_read_addr_2 = rs2;
  assign bus.out_valid       = (state == ST_VALID);
  assign bus.out_opcode      = instr_q[INSTR_W-1:2*ADDR_W];
  assign bus.out_rd          = rs1;
  assign bus.out_op_a        = op_a_q;
  assign bus.out_op_b        = op_b_q;
  assign blk_cnt             = blk_cnt_q;
  assign state_dbg           = state;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, directed scenarios, then randomized traffic
// with an instruction scoreboard and operands predicted from the modelled register contents.
module tb_operand_fetch;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 6;
  localparam int CNT_W  = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] blk_cnt;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .blk_cnt   (blk_cnt),
    .state_dbg (state_dbg)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int t0           = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: write has priority, reads return data one edge later.
  logic [DATA_W-1:0] mem [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= DATA_W'(32'h1000 + i);
      bus.reg_read_data_1 <= '0;
      bus.reg_read_data_2 <= '0;
    end else if (bus.wb_write_en) begin
      mem[bus.wb_write_dest] <= bus.wb_write_data;
    end else if (bus.reg_read_en) begin
      bus.reg_read_data_1 <= mem[bus.reg_read_addr_1];
      bus.reg_read_data_2 <= mem[bus.reg_read_addr_2];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted instructions queue up; each ALU presentation must match the head.
  logic [15:0] exp_q [$];

  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_instr);
  end

  bit          presenting = 1'b0;
  logic [15:0] cur;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  always @(negedge clk) begin
    if (rst) begin
      presenting = 1'b0;
    end else if (bus.out_valid) begin
      if (!presenting) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL sb_unexpected_output: out_valid with empty expected queue");
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        exp_a      = mem[cur[9:5]];
        exp_b      = mem[cur[4:0]];
        presenting = 1'b1;
      end
      check("sb_opcode", 32'(bus.out_opcode), 32'(cur[15:10]));
      check("sb_rd",     32'(bus.out_rd),     32'(cur[9:5]));
      check("sb_op_a",   32'(bus.out_op_a),   32'(exp_a));
      check("sb_op_b",   32'(bus.out_op_b),   32'(exp_b));
      if (bus.out_ready) presenting = 1'b0;
    end
  end

  // Driver tasks are entered just after a rising edge.
  task automatic wb_write(input logic [4:0] addr, input logic [15:0] data);
    bus.wb_write_en   = 1'b1;
    bus.wb_write_dest = addr;
    bus.wb_write_data = data;
    @(posedge clk);
    #1;
    bus.wb_write_en = 1'b0;
  endtask

  task automatic accept(input logic [15:0] instr);
    int i;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    i = 0;
    while (!bus.in_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk);
    #1;
    t0           = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run + 1, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit hs;
    bus.in_valid      = 1'b0;
    bus.in_instr      = '0;
    bus.out_ready     = 1'b1;
    bus.wb_write_en   = 1'b0;
    bus.wb_write_dest = '0;
    bus.wb_write_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),    32'd1);
    check("rst_read_en",   32'(bus.reg_read_en), 32'd0);
    check("rst_blk_cnt",   32'(blk_cnt),         32'd0);
    check("rst_state",     32'(state_dbg),       32'(S_IDLE));
    check("rst_op_a",      32'(bus.out_op_a),    32'd0);

    // Plain fetch
    wb_write(5'd3, 16'h0011);
    wb_write(5'd4, 16'h0022);
    accept(16'h0464);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_op_a",   32'(bus.out_op_a),   32'h0011);
    check("t1_op_b",   32'(bus.out_op_b),   32'h0022);
    check("t1_rd",     32'(bus.out_rd),     32'd3);
    check("t1_opcode", 32'(bus.out_opcode), 32'd1);
    @(posedge clk); #1;

    // Write-back in the first READ cycle costs one cycle
    accept(16'h0464);
    bus.wb_write_en   = 1'b1;
    bus.wb_write_dest = 5'd7;
    bus.wb_write_data = 16'h5555;
    @(posedge clk); #1;
    bus.wb_write_en = 1'b0;
    wait_valid(lat);
    check("t2_latency", 32'(lat), 32'd3);
    check("t2_blk_cnt", 32'(blk_cnt), 32'd1);
    check("t2_op_a", 32'(bus.out_op_a), 32'h0011);
    check("t2_op_b", 32'(bus.out_op_b), 32'h0022);
    @(posedge clk); #1;

    // Write-back to rs2 during DATA
    accept(16'h0464);
    @(posedge clk); #1;
    bus.wb_write_en   = 1'b1;
    bus.wb_write_dest = 5'd4;
    bus.wb_write_data = 16'hBEEF;
    @(posedge clk); #1;
    bus.wb_write_en = 1'b0;
    wait_valid(lat);
`ifdef OPFETCH_FWD_EN
    check("t3_latency", 32'(lat), 32'd2);
`else
    check("t3_latency", 32'(lat), 32'd4);
`endif
    check("t3_op_a", 32'(bus.out_op_a), 32'h0011);
    check("t3_op_b", 32'(bus.out_op_b), 32'hBEEF);
    check("t3_blk_cnt", 32'(blk_cnt), 32'd1);
    @(posedge clk); #1;

    // ALU stall in VALID, then back-to-back accept
    bus.out_ready = 1'b0;
    accept(16'h0883);
    wait_valid(lat);
    check("t4_latency", 32'(lat), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h0464;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid",    32'(bus.out_valid),  32'd1);
      check("t4_hold_in_ready", 32'(bus.in_ready),   32'd0);
      check("t4_hold_op_a",     32'(bus.out_op_a),   32'hBEEF);
      check("t4_hold_op_b",     32'(bus.out_op_b),   32'h0011);
      check("t4_hold_opcode",   32'(bus.out_opcode), 32'd2);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus.in_valid = 1'b0;
    check("t4_b2b_state",     32'(state_dbg),     32'(S_READ));
    check("t4_b2b_out_valid", 32'(bus.out_valid), 32'd0);
    wait_valid(lat);
    check("t4_b2b_latency", 32'(lat), 32'd2);
    check("t4_b2b_op_a", 32'(bus.out_op_a), 32'h0011);
    check("t4_b2b_op_b", 32'(bus.out_op_b), 32'hBEEF);
    @(posedge clk); #1;

    // Asynchronous reset while in DATA
    accept(16'h0464);
    @(posedge clk); #1;
    check("t5_pre_state", 32'(state_dbg), 32'(S_DATA));
    #2 rst = 1'b1;
    #1;
    check("t5_out_valid", 32'(bus.out_valid),   32'd0);
    check("t5_read_en",   32'(bus.reg_read_en), 32'd0);
    check("t5_blk_cnt",   32'(blk_cnt),         32'd0);
    check("t5_state",     32'(state_dbg),       32'(S_IDLE));
    check("t5_in_ready",  32'(bus.in_ready),    32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();

    // Long write-back burst saturates the blocked counter
    accept(16'h0464);
    bus.wb_write_en   = 1'b1;
    bus.wb_write_dest = 5'd7;
    bus.wb_write_data = 16'h7777;
    repeat (300) @(posedge clk);
    #1;
    check("t6_state_read", 32'(state_dbg), 32'(S_READ));
    check("t6_blk_sat",    32'(blk_cnt),   32'hFF);
    bus.wb_write_en = 1'b0;
    wait_valid(lat);
    check("t6_latency", 32'(lat), 32'd302);
    check("t6_op_a", 32'(bus.out_op_a), 32'h1003);
    check("t6_op_b", 32'(bus.out_op_b), 32'h1004);
    check("t6_blk_hold", 32'(blk_cnt), 32'hFF);
    @(posedge clk); #1;

    // Randomized traffic with write-back noise on a small register window
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (!bus.in_valid || hs) begin
        bus.in_valid = ($urandom_range(0, 99) < 60);
        bus.in_instr = {6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7))};
      end
      bus.out_ready     = ($urandom_range(0, 99) < 70);
      bus.wb_write_en   = ($urandom_range(0, 99) < 25);
      bus.wb_write_dest = 5'($urandom_range(0, 7));
      bus.wb_write_data = 16'($urandom);
    end
    bus.out_ready   = 1'b1;
    bus.wb_write_en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs) bus.in_valid = 1'b0;
      if (!bus.in_valid && exp_q.size() == 0 && state_dbg == S_IDLE) break;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_state_idle",  32'(state_dbg),    32'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
